pipe_run_ctrl: RTL and testbench
================================

# pipe_run_ctrl

Run/halt sequencer for the 5-stage RISC-V pipeline. It gates instruction fetch and injects ID/EX bubbles so the pipeline can be started, drained on a Halt instruction or a debug halt request, single-stepped and resumed. It also keeps cycle, retire and stall performance counters. It sits beside the datapath and drives the fetch-enable and bubble-inject controls that feed the PC register, IF/ID and ID/EX.

## Interface
Parameters:
- DRAIN_CYC, 3: cycles needed for the instruction in EX to retire through EX/MEM, MEM/WB and the register-file write.
- CNT_W, 32: width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: leave IDLE, or resume from a debug halt.
- step  in  1  pulse: single-step while debug-halted.
- halt_req  in  1  debug halt request, level or pulse.
- halt_ex  in  1  Halt instruction resolved in EX this cycle.
- retire  in  1  a non-bubble instruction completes WB this cycle.
- stall_req  in  1  load-use stall from hazard detection.
- fetch_en  out  1  PC and IF/ID may update.
- inject_nop  out  1  force ID/EX to a bubble.
- halted  out  1  state is HALTED.
- halt_insn  out  1  sticky: halt was caused by halt_ex.
- busy  out  1  state is RUN, STEP or DRAIN.
- cycle_cnt  out  CNT_W  active-cycle count.
- retire_cnt  out  CNT_W  retired-instruction count.
- stall_cnt  out  CNT_W  stall-cycle count.

## Operation
States: IDLE, RUN, DRAIN, STEP, HALTED.
- Reset values: state=IDLE, all counters 0, halt_insn=0, drain counter 0. Outputs after reset: fetch_en=0, inject_nop=1, halted=0, busy=0.
- IDLE: fetch_en=0, inject_nop=1. start moves to RUN.
- RUN: inject_nop=0. fetch_en is Mealy: fetch_en = !halt_ex && !halt_req, so no instruction is fetched in the cycle a halt is seen.
  - halt_ex moves to DRAIN and sets halt_insn.
  - halt_req without halt_ex moves to DRAIN with halt_insn=0.
  - If both arrive together, halt_ex wins.
- DRAIN: fetch_en=0, inject_nop=1. Lasts exactly DRAIN_CYC cycles: the drain counter loads DRAIN_CYC-1 on entry and counts down to 0. It then moves to HALTED. halt_req, halt_ex, start and step are ignored while draining.
- HALTED: fetch_en=0, inject_nop=1, halted=1.
  - If halt_insn=1: start and step are ignored; only reset exits.
  - If halt_insn=0: start moves to RUN and step moves to STEP. If both arrive together, start wins.
- STEP: one cycle with fetch_en=1 and inject_nop=0. The instruction held in IF/ID advances to ID/EX and one new instruction is fetched. The next state is DRAIN, so exactly one instruction retires per step (none if IF/ID held a bubble).
- Counters:
  - cycle_cnt increments every cycle busy=1.
  - retire_cnt increments on retire in any state.
  - stall_cnt increments on stall_req only when state=RUN.
  - All counters wrap modulo 2^CNT_W.
- Reset during any state, including mid-DRAIN, returns to IDLE next edge and clears counters and halt_insn.

## Timing
- All outputs are registered except fetch_en in RUN, which is combinational from halt_ex and halt_req.
- start/step sampled at edge N: the new state and outputs are valid from edge N+1.
- halt_ex at edge N in RUN: DRAIN covers cycles N+1 to N+DRAIN_CYC; halted=1 from edge N+DRAIN_CYC+1.
- Counter values reflect events up to the previous edge (one-cycle visibility latency).
- halt_req held high during DRAIN or HALTED has no effect. In RUN it is re-evaluated each cycle.

## Structure
- Put the state enum typedef (run_state_e: IDLE, RUN, DRAIN, STEP, HALTED) in Pipe_Buf_Reg_PKG, next to the pipeline register structs.
- Put DRAIN_CYC's default of 3 in the same package as a localparam constant.
- One sub-module, perf_counter: parameterised by width, with inputs clk, reset and inc, and output count; it wraps on overflow. Instantiate it three times.
- The FSM and drain counter live in pipe_run_ctrl itself.

## Test plan
- Reset then start at cycle 2: fetch_en=1 from cycle 3. Hold retire=1 for 10 cycles: retire_cnt=10, cycle_cnt=10, halted=0.
- halt_ex at cycle 20 in RUN: fetch_en=0 in cycle 20; inject_nop=1 for cycles 21–23; halted=1 and halt_insn=1 at cycle 24. A later start and step leave halted=1.
- halt_req and halt_ex in the same RUN cycle: halt_insn=1. Separately, halt_req alone, then start after halted: RUN resumes with halt_insn=0 and the counters preserved.
- Debug-halted, step pulse: exactly one cycle of fetch_en=1, then 3 DRAIN cycles, then halted=1. Drive retire=1 once: retire_cnt rises by 1. step and start together: RUN is entered.
- stall_req high for 4 RUN cycles and 2 HALTED cycles: stall_cnt=4. With CNT_W=4, 17 retires: retire_cnt=1.
- reset asserted in the second DRAIN cycle: next edge state=IDLE, halted=0, all counters 0, inject_nop=1.

Source files
------------

// File: rtl/pipe_run_ctrl_pkg.sv
// Shared pipeline-buffer types and run-control constants.
// Imported by the run/halt sequencer and the datapath stages.
package Pipe_Buf_Reg_PKG;

  localparam int DRAIN_CYC_DEFAULT = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    DRAIN  = 3'd2,
    STEP   = 3'd3,
    HALTED = 3'd4
  } run_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        valid;
  } id_ex_t;

endpackage

// File: rtl/pipe_run_ctrl_perf_counter.sv
// Free-running event counter, wraps modulo 2^W.
// Synchronous active-high clear.
module perf_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign count_d = inc ? count_q + W'(1) : count_q;
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run/halt sequencer: gates fetch, injects ID/EX bubbles,
// drains on halt, single-steps, and keeps perf counters.
module pipe_run_ctrl
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             halt_req,
  input  logic             halt_ex,
  input  logic             retire,
  input  logic             stall_req,
  output logic             fetch_en,
  output logic             inject_nop,
  output logic             halted,
  output logic             halt_insn,
  output logic             busy,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYC - 1);

  run_state_e    state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          hi_q, hi_d;

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    hi_d    = hi_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        if (halt_ex || halt_req) begin
          state_d = DRAIN;
          drain_d = DRAIN_LD;
          hi_d    = halt_ex;
        end
      end
      DRAIN: begin
        if (drain_q == '0) state_d = HALTED;
        else               drain_d = drain_q - DW'(1);
      end
      STEP: begin
        state_d = DRAIN;
        drain_d = DRAIN_LD;
      end
      HALTED: begin
        // A Halt instruction is terminal until reset
        if (!hi_q && start)     state_d = RUN;
        else if (!hi_q && step) state_d = STEP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      drain_q <= '0;
      hi_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      hi_q    <= hi_d;
    end
  end

  logic in_run;
  logic in_step;

  assign in_run     = (state_q == RUN);
  assign in_step    = (state_q == STEP);
  assign fetch_en   = (in_run && !halt_ex && !halt_req) || in_step;
  assign inject_nop = !(in_run || in_step);
  assign halted     = (state_q == HALTED);
  assign halt_insn  = hi_q;
  assign busy       = in_run || in_step || (state_q == DRAIN);

  perf_counter #(.W(CNT_W)) u_cyc (
    .clk   (clk),
    .reset (reset),
    .inc   (busy),
    .count (cycle_cnt)
  );

  perf_counter #(.W(CNT_W)) u_ret (
    .clk   (clk),
    .reset (reset),
    .inc   (retire),
    .count (retire_cnt)
  );

  perf_counter #(.W(CNT_W)) u_stl (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_req && in_run),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: behavioural model with per-cycle
// compare plus directed literal expectations.
module tb_pipe_run_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic step = 1'b0;
  logic halt_req = 1'b0;
  logic halt_ex = 1'b0;
  logic retire = 1'b0;
  logic stall_req = 1'b0;

  logic        fetch_en, inject_nop, halted, halt_insn, busy;
  logic [31:0] cycle_cnt, retire_cnt, stall_cnt;
  logic        fetch_en4, inject_nop4, halted4, halt_insn4, busy4;
  logic [3:0]  cycle_cnt4, retire_cnt4, stall_cnt4;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  pipe_run_ctrl #(.DRAIN_CYC(3), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .halt_req(halt_req), .halt_ex(halt_ex), .retire(retire),
    .stall_req(stall_req), .fetch_en(fetch_en),
    .inject_nop(inject_nop), .halted(halted),
    .halt_insn(halt_insn), .busy(busy), .cycle_cnt(cycle_cnt),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  pipe_run_ctrl #(.DRAIN_CYC(3), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .halt_req(halt_req), .halt_ex(halt_ex), .retire(retire),
    .stall_req(stall_req), .fetch_en(fetch_en4),
    .inject_nop(inject_nop4), .halted(halted4),
    .halt_insn(halt_insn4), .busy(busy4), .cycle_cnt(cycle_cnt4),
    .retire_cnt(retire_cnt4), .stall_cnt(stall_cnt4)
  );

  // model: mode plus remaining drain cycles and plain counters
  typedef enum int {M_IDLE, M_RUN, M_DRAIN, M_STEP, M_HALT} mode_e;
  mode_e       m_mode = M_IDLE;
  int          m_left = 0;
  bit          m_hi = 1'b0;
  int unsigned m_cyc = 0, m_ret = 0, m_stl = 0;

  function automatic bit m_busy();
    return m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = M_IDLE; m_left = 0; m_hi = 0;
      m_cyc = 0; m_ret = 0; m_stl = 0;
    end else begin
      if (m_busy()) m_cyc++;
      if (retire) m_ret++;
      if (stall_req && m_mode == M_RUN) m_stl++;
      case (m_mode)
        M_IDLE: if (start) m_mode = M_RUN;
        M_RUN: if (halt_ex || halt_req) begin
          m_mode = M_DRAIN; m_left = 3; m_hi = halt_ex;
        end
        M_STEP: begin m_mode = M_DRAIN; m_left = 3; end
        M_DRAIN: begin
          m_left--;
          if (m_left == 0) m_mode = M_HALT;
        end
        M_HALT: if (!m_hi) begin
          if (start) m_mode = M_RUN;
          else if (step) m_mode = M_STEP;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic efe;
      efe = (m_mode == M_RUN && !halt_ex && !halt_req) || m_mode == M_STEP;
      chk("fetch_en", {31'd0, fetch_en}, {31'd0, efe});
      chk("inject_nop", {31'd0, inject_nop},
          {31'd0, !(m_mode == M_RUN || m_mode == M_STEP)});
      chk("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
      chk("halt_insn", {31'd0, halt_insn}, {31'd0, m_hi});
      chk("busy", {31'd0, busy}, {31'd0, m_busy()});
      chk("cycle_cnt", cycle_cnt, m_cyc);
      chk("retire_cnt", retire_cnt, m_ret);
      chk("stall_cnt", stall_cnt, m_stl);
      chk("fetch_en4", {31'd0, fetch_en4}, {31'd0, efe});
      chk("halted4", {31'd0, halted4}, {31'd0, m_mode == M_HALT});
      chk("cycle_cnt4", {28'd0, cycle_cnt4}, m_cyc & 32'hF);
      chk("retire_cnt4", {28'd0, retire_cnt4}, m_ret & 32'hF);
      chk("stall_cnt4", {28'd0, stall_cnt4}, m_stl & 32'hF);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    chk("rst_fetch", {31'd0, fetch_en}, 32'd0);
    chk("rst_nop", {31'd0, inject_nop}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ret", retire_cnt, 32'd0);

    // start, then 10 retiring RUN cycles
    start = 1; tick(); start = 0;
    chk("run_fetch", {31'd0, fetch_en}, 32'd1);
    retire = 1; repeat (10) tick(); retire = 0;
    chk("ret10", retire_cnt, 32'd10);
    chk("cyc10", cycle_cnt, 32'd10);
    chk("not_halted", {31'd0, halted}, 32'd0);

    // halt instruction: no fetch this cycle, 3 drain cycles
    halt_ex = 1; #1;
    chk("hex_fetch0", {31'd0, fetch_en}, 32'd0);
    tick(); halt_ex = 0;
    chk("drain_nop", {31'd0, inject_nop}, 32'd1);
    tick(); tick();
    chk("drain3_nh", {31'd0, halted}, 32'd0);
    tick();
    chk("hex_halted", {31'd0, halted}, 32'd1);
    chk("hex_hi", {31'd0, halt_insn}, 32'd1);
    start = 1; tick(); start = 0;
    step = 1; tick(); step = 0;
    chk("sticky_halt", {31'd0, halted}, 32'd1);

    // both halts together: instruction halt wins
    do_reset();
    chk("rst2_ret", retire_cnt, 32'd0);
    start = 1; tick(); start = 0;
    halt_req = 1; halt_ex = 1; tick(); halt_req = 0; halt_ex = 0;
    repeat (3) tick();
    chk("both_hi", {31'd0, halt_insn}, 32'd1);

    // debug halt, held through drain, then resume
    do_reset();
    start = 1; tick(); start = 0;
    retire = 1; repeat (3) tick(); retire = 0;
    halt_req = 1; repeat (4) tick(); halt_req = 0;
    chk("dbg_halted", {31'd0, halted}, 32'd1);
    chk("dbg_hi", {31'd0, halt_insn}, 32'd0);
    start = 1; tick(); start = 0;
    chk("resume_busy", {31'd0, busy}, 32'd1);
    chk("resume_ret", retire_cnt, 32'd3);

    // single step
    halt_req = 1; tick(); halt_req = 0;
    repeat (3) tick();
    step = 1; tick(); step = 0;
    chk("step_fetch", {31'd0, fetch_en}, 32'd1);
    chk("step_nop", {31'd0, inject_nop}, 32'd0);
    retire = 1; tick(); retire = 0;
    chk("step_drain_fe", {31'd0, fetch_en}, 32'd0);
    tick(); tick();
    chk("step_nh", {31'd0, halted}, 32'd0);
    tick();
    chk("step_halted", {31'd0, halted}, 32'd1);
    chk("step_ret", retire_cnt, 32'd4);

    // step and start together: RUN
    step = 1; start = 1; tick(); step = 0; start = 0;
    tick();
    chk("st_run_fe", {31'd0, fetch_en}, 32'd1);

    // stalls count only in RUN
    stall_req = 1; repeat (4) tick(); stall_req = 0;
    halt_req = 1; tick(); halt_req = 0;
    repeat (3) tick();
    stall_req = 1; repeat (2) tick(); stall_req = 0;
    chk("stall4", stall_cnt, 32'd4);

    // narrow counter wrap
    do_reset();
    start = 1; tick(); start = 0;
    retire = 1; repeat (17) tick(); retire = 0;
    chk("wrap4", {28'd0, retire_cnt4}, 32'd1);
    chk("nowrap32", retire_cnt, 32'd17);

    // reset in the second drain cycle
    halt_req = 1; tick(); halt_req = 0;
    tick();
    do_reset();
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_nop", {31'd0, inject_nop}, 32'd1);
    chk("mid_rst_cyc", cycle_cnt, 32'd0);
    chk("mid_rst_ret", retire_cnt, 32'd0);
    tick();

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
